// File: rtl/fft_pkg.sv
// Shared FFT types and helpers: complex sample type, log2 and index bit-reversal.
package fft_pkg;

   // One complex sample, real part in the upper word.
   typedef struct packed {
      logic [31:0] r;
      logic [31:0] i;
   } complex_t;

   // Emit-side state of the frame loader.
   typedef enum logic {
      EMIT_IDLE  = 1'b0,
      EMIT_PULSE = 1'b1
   } emit_state_e;

   // Ceiling log2, used for index and counter widths (N is a power of two).
   function automatic int fft_log2(input int n);
      int r;
      r = 0;
      for (int b = 0; b < 31; b++) begin
         if ((1 << b) < n) r = b + 1;
      end
      return r;
   endfunction

   // Reverse the low 'bits' bits of k (bits <= 4 covers frames up to 16).
   function automatic int bitrev_idx(input int k, input int bits);
      int r;
      r = 0;
      for (int b = 0; b < 4; b++) begin
         if (b < bits && ((k >> b) & 1) != 0) r = r | (1 << (bits - 1 - b));
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One N-entry complex sample bank: single indexed write port, all entries readable in parallel.
module fft_frame_bank
   import fft_pkg::*;
#(
   parameter  int N     = 4,
   localparam int IDX_W = fft_log2(N)
) (
   input  logic               clk,
   input  logic               wr_en_i,
   input  logic [IDX_W-1:0]   wr_idx_i,
   input  complex_t           wr_data_i,
   output complex_t [N-1:0]   rd_data_o
);

   for (genvar gi = 0; gi < N; gi++) begin : g_entry
      complex_t entry_q;

      // Entry loads only when it is the addressed slot of an accepted sample.
      always_ff @(posedge clk) begin
         if (wr_en_i && (wr_idx_i == IDX_W'(gi))) begin
            entry_q <= wr_data_i;
         end
      end

      assign rd_data_o[gi] = entry_q;
   end

endmodule

// File: rtl/fft_frame_loader.sv
// Stream-to-frame front end for the fftN cores. Collects N samples per frame into a
// ping-pong pair of banks and presents each complete frame in parallel with a one-cycle
// next strobe, spaced at least GAP_CYC cycles apart.
// Build option: define FFT_LOADER_BITREV_EN to store sample k at bit-reversed index,
// so the core receives the frame in bit-reversed order. Handshake and timing are unchanged.
module fft_frame_loader
   import fft_pkg::*;
#(
   parameter int N       = 4,
   parameter int GAP_CYC = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  complex_t in_data,
   input  logic     in_valid,
   output logic     in_ready,
   input  logic     in_sof,
   output complex_t out_data [0:N-1],
   output logic     next
);

   localparam int IDX_W = fft_log2(N);
   localparam int GAP_W = fft_log2(GAP_CYC + 1);

   // Write side
   logic              wr_bank_q;
   logic [IDX_W-1:0]  wr_idx_q;
   logic [1:0]        full_q;
   logic [1:0]        full_d;

   // Emit side
   logic              rd_bank_q;
   logic [GAP_W-1:0]  gap_cnt_q;
   emit_state_e       state_q;
   logic              next_q;
   complex_t [N-1:0]  out_q;

   logic              xfer;
   logic [IDX_W-1:0]  wr_pos;
   logic [IDX_W-1:0]  wr_addr;
   logic              frame_done;
   logic              emit;
   logic [1:0]        bank_we;
   complex_t [N-1:0]  bank_rd [2];

   // Ready depends only on registered flags, never on in_valid.
   assign in_ready   = ~full_q[wr_bank_q];
   assign xfer       = in_valid && ~full_q[wr_bank_q];
   // A start-of-frame sample always lands in slot 0, dropping any partial frame.
   assign wr_pos     = in_sof ? '0 : wr_idx_q;
   assign frame_done = xfer && (wr_pos == IDX_W'(N - 1));
   assign emit       = full_q[rd_bank_q] && (gap_cnt_q == '0);

`ifdef FFT_LOADER_BITREV_EN
   assign wr_addr = IDX_W'(bitrev_idx(int'(wr_pos), IDX_W));
`else
   assign wr_addr = wr_pos;
`endif

   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign bank_we[gi] = xfer && (wr_bank_q == 1'(gi));

      fft_frame_bank #(
         .N (N)
      ) u_bank (
         .clk       (clk),
         .wr_en_i   (bank_we[gi]),
         .wr_idx_i  (wr_addr),
         .wr_data_i (in_data),
         .rd_data_o (bank_rd[gi])
      );
   end

   // Bank occupancy: emit frees the read bank while a completing frame may fill the other.
   always_comb begin
      full_d = full_q;
      if (emit)       full_d[rd_bank_q] = 1'b0;
      if (frame_done) full_d[wr_bank_q] = 1'b1;
   end

   // Write pointer and bank selection for incoming samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_bank_q <= 1'b0;
         wr_idx_q  <= '0;
         full_q    <= 2'b00;
      end else begin
         full_q <= full_d;
         if (xfer) begin
            wr_idx_q <= frame_done ? '0 : wr_pos + IDX_W'(1);
         end
         if (frame_done) begin
            wr_bank_q <= ~wr_bank_q;
         end
      end
   end

   // Emit FSM: pulse next with the captured frame, then hold off for GAP_CYC cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= EMIT_IDLE;
         next_q    <= 1'b0;
         rd_bank_q <= 1'b0;
         gap_cnt_q <= '0;
         out_q     <= '0;
      end else begin
         case (state_q)
            EMIT_IDLE, EMIT_PULSE: begin
               if (emit) begin
                  // Back-to-back pulses are only possible when GAP_CYC is 1.
                  state_q   <= EMIT_PULSE;
                  next_q    <= 1'b1;
                  out_q     <= bank_rd[rd_bank_q];
                  rd_bank_q <= ~rd_bank_q;
                  gap_cnt_q <= GAP_W'(GAP_CYC - 1);
               end else begin
                  state_q <= EMIT_IDLE;
                  next_q  <= 1'b0;
                  if (gap_cnt_q != '0) begin
                     gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                  end
               end
            end
            default: begin
               state_q <= EMIT_IDLE;
               next_q  <= 1'b0;
            end
         endcase
      end
   end

   assign next = next_q;

   for (genvar gi = 0; gi < N; gi++) begin : g_out
      assign out_data[gi] = out_q[gi];
   end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: instance A (N=4, GAP_CYC=8) and instance B (N=8, GAP_CYC=2).
// Expected frames are built from accepted samples and queued; observed frames are queued
// by a monitor on each next pulse and compared per scenario.
module tb_fft_frame_loader;
   import fft_pkg::*;

   localparam int NA = 4;
   localparam int GA = 8;
   localparam int NB = 8;
   localparam int GB = 2;
   localparam int FW = 1024;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   complex_t in_data_a = '0;
   complex_t in_data_b = '0;
   logic in_valid_a = 1'b0, in_valid_b = 1'b0;
   logic in_sof_a = 1'b0, in_sof_b = 1'b0;
   logic in_ready_a, in_ready_b, next_a, next_b;
   complex_t out_a [0:NA-1];
   complex_t out_b [0:NB-1];

   fft_frame_loader #(.N(NA), .GAP_CYC(GA)) dut_a (
      .clk(clk), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
      .in_ready(in_ready_a), .in_sof(in_sof_a), .out_data(out_a), .next(next_a)
   );

   fft_frame_loader #(.N(NB), .GAP_CYC(GB)) dut_b (
      .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
      .in_ready(in_ready_b), .in_sof(in_sof_b), .out_data(out_b), .next(next_b)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic rst_q = 1'b1;

   typedef struct packed {
      logic [FW-1:0] d;
      int            stamp;
   } obs_t;

   obs_t          obs_a[$], obs_b[$];
   logic [FW-1:0] exp_a[$], exp_b[$];
   logic [FW-1:0] part_a = '0, part_b = '0;
   int            idx_a = 0, idx_b = 0;
   logic [FW-1:0] last_a = '0, last_b = '0;
   int            unstable_a = 0, unstable_b = 0;
   logic [FW-1:0] got_q[$], want_q[$];
   int            stamp_q[$];
   int            got_cnt = 0;

   // Expected storage slot of sample k in an n-sample frame.
   function automatic int tb_map(input int k, input int n);
`ifdef FFT_LOADER_BITREV_EN
      int r;
      int b;
      r = 0;
      b = (n == 4) ? 2 : (n == 8) ? 3 : 4;
      for (int j = 0; j < b; j++) if ((k & (1 << j)) != 0) r = r | (1 << (b - 1 - j));
      return r;
`else
      return k;
`endif
   endfunction

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   // Monitor: capture frames on next, and flag any out_data change between pulses.
   always @(negedge clk) begin : mon
      logic [FW-1:0] ca, cb;
      ca = '0;
      cb = '0;
      for (int k = 0; k < NA; k++) ca[k*64 +: 64] = out_a[k];
      for (int k = 0; k < NB; k++) cb[k*64 +: 64] = out_b[k];
      if (rst_q) last_a = ca;
      else if (next_a) begin obs_a.push_back('{d: ca, stamp: cyc}); last_a = ca; end
      else if (ca !== last_a) unstable_a++;
      if (rst_q) last_b = cb;
      else if (next_b) begin obs_b.push_back('{d: cb, stamp: cyc}); last_b = cb; end
      else if (cb !== last_b) unstable_b++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic model_accept(input int sel, input complex_t s, input logic sof);
      if (sel == 0) begin
         if (sof) idx_a = 0;
         part_a[tb_map(idx_a, NA)*64 +: 64] = s;
         idx_a++;
         if (idx_a == NA) begin exp_a.push_back(part_a); idx_a = 0; end
      end else begin
         if (sof) idx_b = 0;
         part_b[tb_map(idx_b, NB)*64 +: 64] = s;
         idx_b++;
         if (idx_b == NB) begin exp_b.push_back(part_b); idx_b = 0; end
      end
   endtask

   task automatic model_reset();
      idx_a = 0; idx_b = 0;
      exp_a.delete(); exp_b.delete();
      obs_a.delete(); obs_b.delete();
   endtask

   // Offer one sample at a negedge; returns the cycle number of the accepting edge.
   task automatic push(input int sel, input int r, input int i, input logic sof, output int acc);
      int waited;
      complex_t s;
      waited = 0;
      s.r = 32'(r);
      s.i = 32'(i);
      if (sel == 0) begin in_data_a = s; in_sof_a = sof; in_valid_a = 1'b1; end
      else          begin in_data_b = s; in_sof_b = sof; in_valid_b = 1'b1; end
      while (((sel == 0) ? !in_ready_a : !in_ready_b) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 100) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout sel=%0d got ready=0 for %0d cycles want ready=1", sel, waited);
      end
      acc = cyc + 1;
      model_accept(sel, s, sof);
      @(negedge clk);
      if (sel == 0) begin in_valid_a = 1'b0; in_sof_a = 1'b0; end
      else          begin in_valid_b = 1'b0; in_sof_b = 1'b0; end
   endtask

   // Wait (bounded) for frames, then pair observed frames with expected ones.
   task automatic collect(input int sel, input int nexp);
      int w;
      obs_t o;
      w = 0;
      got_q.delete(); want_q.delete(); stamp_q.delete();
      while (((sel == 0) ? obs_a.size() : obs_b.size()) < nexp && w < 500) begin
         @(negedge clk);
         w++;
      end
      repeat (30) @(negedge clk);
      got_cnt = (sel == 0) ? obs_a.size() : obs_b.size();
      if (sel == 0) begin
         while (obs_a.size() > 0 && exp_a.size() > 0) begin
            o = obs_a.pop_front();
            got_q.push_back(o.d); stamp_q.push_back(o.stamp); want_q.push_back(exp_a.pop_front());
         end
         obs_a.delete(); exp_a.delete();
      end else begin
         while (obs_b.size() > 0 && exp_b.size() > 0) begin
            o = obs_b.pop_front();
            got_q.push_back(o.d); stamp_q.push_back(o.stamp); want_q.push_back(exp_b.pop_front());
         end
         obs_b.delete(); exp_b.delete();
      end
   endtask

   task automatic test_reset();
      logic zero_a, zero_b;
      repeat (2) @(negedge clk);
      zero_a = 1'b1; zero_b = 1'b1;
      for (int k = 0; k < NA; k++) if (out_a[k] !== '0) zero_a = 1'b0;
      for (int k = 0; k < NB; k++) if (out_b[k] !== '0) zero_b = 1'b0;
      checks++;
      if (next_a !== 1'b0 || next_b !== 1'b0) begin errors++; $display("FAIL reset_next got %b%b want 00", next_a, next_b); end
      checks++;
      if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b want 11", in_ready_a, in_ready_b); end
      checks++;
      if (!zero_a || !zero_b) begin errors++; $display("FAIL reset_out_zero got zero_a=%b zero_b=%b want 1 1", zero_a, zero_b); end
      $display("[%0t] reset held 2 cycles, state checked", $time);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_single_frame();
      int acc;
      acc = 0;
      for (int k = 0; k < 4; k++) push(0, k, 100 + k, k == 0, acc);
      collect(0, 1);
      checks++;
      if (got_cnt !== 1) begin errors++; $display("FAIL single_count got %0d want 1", got_cnt); end
      foreach (got_q[j]) begin
         checks++;
         if (got_q[j] !== want_q[j]) begin errors++; $display("FAIL single_frame got %h want %h", got_q[j][NA*64-1:0], want_q[j][NA*64-1:0]); end
         else $display("[%0t] single frame %0d out_data=%h", $time, j, got_q[j][NA*64-1:0]);
      end
      checks++;
      if (stamp_q.size() < 1 || stamp_q[0] != acc + 1) begin
         errors++;
         $display("FAIL single_latency got cycle %0d want %0d", (stamp_q.size() > 0) ? stamp_q[0] : -1, acc + 1);
      end
   endtask

   task automatic test_gap_stream();
      int acc;
      acc = 0;
      for (int k = 0; k < 12; k++) push(0, 200 + k, k, k == 0, acc);
      checks++;
      if (in_ready_a !== 1'b0) begin errors++; $display("FAIL gap_ready_both_full got %b want 0", in_ready_a); end
      collect(0, 3);
      checks++;
      if (got_cnt !== 3) begin errors++; $display("FAIL gap_count got %0d want 3", got_cnt); end
      foreach (got_q[j]) begin
         checks++;
         if (got_q[j] !== want_q[j]) begin errors++; $display("FAIL gap_frame%0d got %h want %h", j, got_q[j][NA*64-1:0], want_q[j][NA*64-1:0]); end
         else $display("[%0t] gap frame %0d at cycle %0d out_data=%h", $time, j, stamp_q[j], got_q[j][NA*64-1:0]);
      end
      checks++;
      if (stamp_q.size() < 3 || stamp_q[1] - stamp_q[0] != GA || stamp_q[2] - stamp_q[1] != GA) begin
         errors++;
         $display("FAIL gap_spacing got %0d pulses (first spacing %0d) want spacing %0d",
                  stamp_q.size(), (stamp_q.size() > 1) ? stamp_q[1] - stamp_q[0] : -1, GA);
      end
   endtask

   task automatic test_sof_resync();
      int acc;
      acc = 0;
      push(0, 1, 1, 1'b1, acc);
      push(0, 2, 2, 1'b0, acc);
      push(0, 7, 7, 1'b1, acc);
      for (int k = 8; k < 11; k++) push(0, k, k, 1'b0, acc);
      collect(0, 1);
      checks++;
      if (got_cnt !== 1) begin errors++; $display("FAIL sof_count got %0d want 1", got_cnt); end
      foreach (got_q[j]) begin
         checks++;
         if (got_q[j] !== want_q[j]) begin errors++; $display("FAIL sof_frame got %h want %h", got_q[j][NA*64-1:0], want_q[j][NA*64-1:0]); end
         else $display("[%0t] sof resync frame out_data=%h", $time, got_q[j][NA*64-1:0]);
      end
   endtask

   task automatic test_bitrev();
      int acc;
      logic [31:0] slot1_r;
      logic [31:0] want_r;
      acc = 0;
      for (int k = 0; k < NB; k++) push(1, k, 50 + k, k == 0, acc);
      collect(1, 1);
      checks++;
      if (got_cnt !== 1) begin errors++; $display("FAIL order_count got %0d want 1", got_cnt); end
      foreach (got_q[j]) begin
         checks++;
         if (got_q[j] !== want_q[j]) begin errors++; $display("FAIL order_frame got %h want %h", got_q[j][NB*64-1:0], want_q[j][NB*64-1:0]); end
         else $display("[%0t] order frame out_data=%h", $time, got_q[j][NB*64-1:0]);
      end
`ifdef FFT_LOADER_BITREV_EN
      want_r = 32'd4;
`else
      want_r = 32'd1;
`endif
      slot1_r = (got_q.size() > 0) ? got_q[0][64+32 +: 32] : 32'hFFFF_FFFF;
      checks++;
      if (slot1_r !== want_r) begin errors++; $display("FAIL order_slot1_r got %0d want %0d", slot1_r, want_r); end
   endtask

   task automatic test_back_to_back();
      int acc;
      int acc8;
      acc = 0;
      acc8 = 0;
      for (int k = 0; k < 3 * NB; k++) begin
         push(1, 1000 + k, 2000 + k, (k % NB) == 0, acc);
         if (k == NB - 1) acc8 = acc;
      end
      collect(1, 3);
      checks++;
      if (got_cnt !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got_cnt); end
      foreach (got_q[j]) begin
         checks++;
         if (got_q[j] !== want_q[j]) begin errors++; $display("FAIL b2b_frame%0d got %h want %h", j, got_q[j][NB*64-1:0], want_q[j][NB*64-1:0]); end
         else $display("[%0t] b2b frame %0d at cycle %0d", $time, j, stamp_q[j]);
      end
      checks++;
      if (stamp_q.size() < 3 || stamp_q[0] != acc8 + 1 || stamp_q[1] - stamp_q[0] != NB || stamp_q[2] - stamp_q[1] != NB) begin
         errors++;
         $display("FAIL b2b_timing got first %0d want %0d (pulses %0d, spacing want %0d)",
                  (stamp_q.size() > 0) ? stamp_q[0] : -1, acc8 + 1, stamp_q.size(), NB);
      end
   endtask

   task automatic test_reset_midframe();
      int acc;
      logic zero_a;
      acc = 0;
      for (int k = 0; k < 3; k++) push(0, 90 + k, 90 + k, k == 0, acc);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      zero_a = 1'b1;
      for (int k = 0; k < NA; k++) if (out_a[k] !== '0) zero_a = 1'b0;
      checks++;
      if (!zero_a || next_a !== 1'b0 || in_ready_a !== 1'b1) begin
         errors++;
         $display("FAIL midreset_state got zero=%b next=%b ready=%b want 1 0 1", zero_a, next_a, in_ready_a);
      end
      for (int k = 0; k < 4; k++) push(0, 300 + k, 400 + k, k == 0, acc);
      collect(0, 1);
      checks++;
      if (got_cnt !== 1) begin errors++; $display("FAIL midreset_count got %0d want 1", got_cnt); end
      foreach (got_q[j]) begin
         checks++;
         if (got_q[j] !== want_q[j]) begin errors++; $display("FAIL midreset_frame got %h want %h", got_q[j][NA*64-1:0], want_q[j][NA*64-1:0]); end
         else $display("[%0t] post-reset frame out_data=%h", $time, got_q[j][NA*64-1:0]);
      end
   endtask

   task automatic test_stability();
      checks++;
      if (unstable_a !== 0) begin errors++; $display("FAIL hold_a got %0d changes between pulses want 0", unstable_a); end
      checks++;
      if (unstable_b !== 0) begin errors++; $display("FAIL hold_b got %0d changes between pulses want 0", unstable_b); end
      $display("[%0t] out_data hold checked on both instances", $time);
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_gap_stream();
      test_sof_resync();
      test_bitrev();
      test_back_to_back();
      test_reset_midframe();
      test_stability();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
